// File: rtl/mcpu_mem_ltc_sram_if.sv
// ---------------------------------------------------------------------------
// mcpu_mem_ltc_sram_if
// Purpose : LTC-side request/response bundle between the memory arbiter
//           (master) and the last-level-cache stand-in (slave).
// Signals : arb2ltc_valid   request valid (master -> slave)
//           arb2ltc_opcode  3-bit LTC opcode (master -> slave)
//           arb2ltc_addr    line address [31:5] (master -> slave)
//           arb2ltc_wdata   256-bit write data (master -> slave)
//           arb2ltc_wbe     32 byte enables, bit i covers wdata[8i+7:8i]
//           arb2ltc_stall   request not accepted this cycle (slave -> master)
//           arb2ltc_rdata   256-bit read data (slave -> master)
//           arb2ltc_rvalid  one-cycle pulse per completed read (slave -> master)
// ---------------------------------------------------------------------------
interface mcpu_mem_ltc_sram_if;
  logic          arb2ltc_valid;
  logic [2:0]    arb2ltc_opcode;
  logic [31:5]   arb2ltc_addr;
  logic [255:0]  arb2ltc_wdata;
  logic [31:0]   arb2ltc_wbe;
  logic          arb2ltc_stall;
  logic [255:0]  arb2ltc_rdata;
  logic          arb2ltc_rvalid;

  modport master (
    output arb2ltc_valid, arb2ltc_opcode, arb2ltc_addr, arb2ltc_wdata, arb2ltc_wbe,
    input  arb2ltc_stall, arb2ltc_rdata, arb2ltc_rvalid
  );

  modport slave (
    input  arb2ltc_valid, arb2ltc_opcode, arb2ltc_addr, arb2ltc_wdata, arb2ltc_wbe,
    output arb2ltc_stall, arb2ltc_rdata, arb2ltc_rvalid
  );
endinterface

// File: rtl/mcpu_mem_ltc_sram.sv
// ---------------------------------------------------------------------------
// mcpu_mem_ltc_sram
// Purpose : SRAM-backed responder standing in for the last-level cache.
//           Accepts one 256-bit line request per cycle, applies byte-enabled
//           writes at the accept edge and returns read data in order after a
//           fixed RD_LATENCY-cycle pipe. Optional LFSR stall injection.
// Ports   : clkrst_mem_clk  clock, rising edge
//           clkrst_mem_rst  synchronous active-high reset
//           arb2ltc         request/response bundle (slave modport)
// Opcodes : 3'b000 READ, 3'b001 WRITE, 3'b010 READTHROUGH,
//           3'b011 WRITETHROUGH; all others are accepted as no-ops.
// ---------------------------------------------------------------------------
module mcpu_mem_ltc_sram #(
  parameter int ADDR_BITS    = 10,
  parameter int RD_LATENCY   = 2,   // 1..8
  parameter int STALL_EN     = 0,
  parameter int STALL_THRESH = 4    // 0 = never stall, 16 = always stall
) (
  input  logic                 clkrst_mem_clk,
  input  logic                 clkrst_mem_rst,
  mcpu_mem_ltc_sram_if.slave   arb2ltc
);

  localparam logic [2:0] OP_READ         = 3'b000;
  localparam logic [2:0] OP_WRITE        = 3'b001;
  localparam logic [2:0] OP_READTHROUGH  = 3'b010;
  localparam logic [2:0] OP_WRITETHROUGH = 3'b011;

  localparam int         DEPTH      = 1 << ADDR_BITS;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // -------------------------------------------------------------------------
  // Request decode
  // -------------------------------------------------------------------------
  logic                 accept;
  logic                 is_read;
  logic                 is_write;
  logic [ADDR_BITS-1:0] idx;
  logic                 stall_q, stall_d;

  always_comb begin
    accept   = arb2ltc.arb2ltc_valid && !stall_q;
    // Upper address bits are dropped, so lines alias modulo DEPTH.
    idx      = arb2ltc.arb2ltc_addr[5+ADDR_BITS-1:5];
    is_read  = accept && (arb2ltc.arb2ltc_opcode == OP_READ ||
                          arb2ltc.arb2ltc_opcode == OP_READTHROUGH);
    is_write = accept && (arb2ltc.arb2ltc_opcode == OP_WRITE ||
                          arb2ltc.arb2ltc_opcode == OP_WRITETHROUGH);
  end

  logic unused_addr_hi;
  assign unused_addr_hi = ^arb2ltc.arb2ltc_addr[31:5+ADDR_BITS];

  // -------------------------------------------------------------------------
  // Line array
  // -------------------------------------------------------------------------
  logic [255:0] mem_q [DEPTH];

  // NOTE: the array is deliberately left out of reset; contents survive a
  // reset pulse and a reset port here would prevent mapping onto an SRAM macro.
  always_ff @(posedge clkrst_mem_clk) begin
    if (is_write) begin
      for (int b = 0; b < 32; b++) begin
        if (arb2ltc.arb2ltc_wbe[b]) begin
          mem_q[idx][8*b +: 8] <= arb2ltc.arb2ltc_wdata[8*b +: 8];
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Read pipe: stage 0 samples the array at the accept edge, the last stage
  // drives the response. Data stages only load behind a valid bit so rdata
  // holds its last value between pulses.
  // -------------------------------------------------------------------------
  logic [RD_LATENCY-1:0] vld_q, vld_d;
  logic [255:0]          data_q [RD_LATENCY];
  logic [255:0]          data_d [RD_LATENCY];

  // NOTE: every combinational output gets a default before any condition,
  // otherwise a missed branch infers a latch.
  always_comb begin
    vld_d  = '0;
    data_d = data_q;
    vld_d[0] = is_read;
    if (is_read) begin
      data_d[0] = mem_q[idx];
    end
    for (int i = 1; i < RD_LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
      if (vld_q[i-1]) begin
        data_d[i] = data_q[i-1];
      end
    end
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge value regardless of statement order.
  always_ff @(posedge clkrst_mem_clk) begin
    if (clkrst_mem_rst) begin
      vld_q <= '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
    end
  end

  // -------------------------------------------------------------------------
  // Stall injection: 16-bit Fibonacci LFSR, taps 16,14,13,11, free-running.
  // The stall flop compares the previous cycle's LFSR state.
  // -------------------------------------------------------------------------
  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    stall_d = (STALL_EN != 0) && ({1'b0, lfsr_q[3:0]} < 5'(STALL_THRESH));
  end

  always_ff @(posedge clkrst_mem_clk) begin
    if (clkrst_mem_rst) begin
      lfsr_q  <= LFSR_SEED;
      stall_q <= 1'b0;
    end else begin
      lfsr_q  <= lfsr_d;
      stall_q <= stall_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign arb2ltc.arb2ltc_stall  = stall_q;
  assign arb2ltc.arb2ltc_rvalid = vld_q[RD_LATENCY-1];
  assign arb2ltc.arb2ltc_rdata  = data_q[RD_LATENCY-1];

endmodule

// File: tb/tb_mcpu_mem_ltc_sram.sv
// ---------------------------------------------------------------------------
// tb_mcpu_mem_ltc_sram
// Three instances share one request driver; only the selected one sees
// arb2ltc_valid. dut0: no stall, dut1: STALL_THRESH=8, dut2: STALL_THRESH=16.
// Read expectations go into a scoreboard queue at acceptance and are popped
// when rvalid is seen, checking data and latency.
// ---------------------------------------------------------------------------
module tb_mcpu_mem_ltc_sram;
  localparam int LAT = 2;
  localparam logic [2:0] OP_READ         = 3'b000;
  localparam logic [2:0] OP_WRITE        = 3'b001;
  localparam logic [2:0] OP_READTHROUGH  = 3'b010;
  localparam logic [2:0] OP_WRITETHROUGH = 3'b011;
  localparam logic [2:0] OP_OTHER4       = 3'b100;
  localparam logic [2:0] OP_OTHER7       = 3'b111;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  logic         req_valid = 1'b0;
  logic [2:0]   req_op    = 3'b000;
  logic [31:5]  req_addr  = '0;
  logic [255:0] req_wdata = '0;
  logic [31:0]  req_wbe   = '0;
  int           sel       = 0;

  mcpu_mem_ltc_sram_if if0 ();
  mcpu_mem_ltc_sram_if if1 ();
  mcpu_mem_ltc_sram_if if2 ();

  assign if0.arb2ltc_valid  = req_valid && (sel == 0);
  assign if0.arb2ltc_opcode = req_op;
  assign if0.arb2ltc_addr   = req_addr;
  assign if0.arb2ltc_wdata  = req_wdata;
  assign if0.arb2ltc_wbe    = req_wbe;
  assign if1.arb2ltc_valid  = req_valid && (sel == 1);
  assign if1.arb2ltc_opcode = req_op;
  assign if1.arb2ltc_addr   = req_addr;
  assign if1.arb2ltc_wdata  = req_wdata;
  assign if1.arb2ltc_wbe    = req_wbe;
  assign if2.arb2ltc_valid  = req_valid && (sel == 2);
  assign if2.arb2ltc_opcode = req_op;
  assign if2.arb2ltc_addr   = req_addr;
  assign if2.arb2ltc_wdata  = req_wdata;
  assign if2.arb2ltc_wbe    = req_wbe;

  mcpu_mem_ltc_sram #(.ADDR_BITS(10), .RD_LATENCY(LAT), .STALL_EN(0), .STALL_THRESH(4)) dut0 (
    .clkrst_mem_clk(clk), .clkrst_mem_rst(rst), .arb2ltc(if0.slave));
  mcpu_mem_ltc_sram #(.ADDR_BITS(10), .RD_LATENCY(LAT), .STALL_EN(1), .STALL_THRESH(8)) dut1 (
    .clkrst_mem_clk(clk), .clkrst_mem_rst(rst), .arb2ltc(if1.slave));
  mcpu_mem_ltc_sram #(.ADDR_BITS(10), .RD_LATENCY(LAT), .STALL_EN(1), .STALL_THRESH(16)) dut2 (
    .clkrst_mem_clk(clk), .clkrst_mem_rst(rst), .arb2ltc(if2.slave));

  logic cur_stall;
  always_comb begin
    cur_stall = if0.arb2ltc_stall;
    if (sel == 1) cur_stall = if1.arb2ltc_stall;
    if (sel == 2) cur_stall = if2.arb2ltc_stall;
  end

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // -------------------------------------------------------------------------
  // Scoreboard
  // -------------------------------------------------------------------------
  typedef struct {
    logic [255:0] data;
    int           acc;   // cycle count after the accept edge
  } exp_t;

  exp_t sbq[$];
  int   rd_pops[3];
  int   rv_seen[3];

  always @(negedge clk) begin : monitor
    logic         rv [3];
    logic [255:0] rd [3];
    exp_t         e;
    rv[0] = if0.arb2ltc_rvalid; rd[0] = if0.arb2ltc_rdata;
    rv[1] = if1.arb2ltc_rvalid; rd[1] = if1.arb2ltc_rdata;
    rv[2] = if2.arb2ltc_rvalid; rd[2] = if2.arb2ltc_rdata;
    for (int d = 0; d < 3; d++) begin
      if (rv[d] === 1'b1) begin
        rv_seen[d]++;
        if (d != sel || sbq.size() == 0) begin
          check($sformatf("unexpected_rvalid_dut%0d", d), 256'd1, 256'd0);
        end else begin
          e = sbq.pop_front();
          check($sformatf("rdata_dut%0d", d), rd[d], e.data);
          check($sformatf("rd_latency_dut%0d", d), 256'(cyc), 256'(e.acc + LAT - 1));
          rd_pops[d]++;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Reference LFSR / stall model for the two stalling instances
  // -------------------------------------------------------------------------
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  logic [15:0] m_lfsr1 = 16'hACE1, m_lfsr2 = 16'hACE1;
  logic        m_stall1 = 1'b0, m_stall2 = 1'b0;
  int          stall_mis1 = 0, stall_mis2 = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_lfsr1 <= 16'hACE1; m_stall1 <= 1'b0;
      m_lfsr2 <= 16'hACE1; m_stall2 <= 1'b0;
    end else begin
      m_stall1 <= ({1'b0, m_lfsr1[3:0]} < 5'd8);
      m_stall2 <= ({1'b0, m_lfsr2[3:0]} < 5'd16);
      m_lfsr1  <= lfsr_next(m_lfsr1);
      m_lfsr2  <= lfsr_next(m_lfsr2);
    end
  end

  bit rand_phase = 1'b0;
  int st_tot = 0, st_hi = 0;

  always @(negedge clk) begin
    if (if1.arb2ltc_stall !== m_stall1) stall_mis1++;
    if (if2.arb2ltc_stall !== m_stall2) stall_mis2++;
    if (rand_phase) begin
      st_tot++;
      if (if1.arb2ltc_stall === 1'b1) st_hi++;
    end
  end

  // -------------------------------------------------------------------------
  // Driver: present a request at a negedge and hold it while stalled. The
  // request is accepted at the next posedge once stall is low.
  // -------------------------------------------------------------------------
  task automatic issue(input logic [2:0] op, input logic [31:5] addr,
                       input logic [255:0] wd, input logic [31:0] wbe,
                       input bit push, input logic [255:0] exp, output bit ok);
    int   waited;
    exp_t e;
    waited = 0;
    ok     = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd; req_wbe = wbe;
    while (cur_stall === 1'b1) begin
      waited++;
      if (waited > 100) begin
        check("accept_timeout", 256'd0, 256'd1);
        req_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    ok = 1'b1;
    if (push && (op == OP_READ || op == OP_READTHROUGH)) begin
      e.data = exp;
      e.acc  = cyc + 1;
      sbq.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [255:0] merge(input logic [255:0] old, input logic [255:0] wd,
                                         input logic [31:0] wbe);
    logic [255:0] r;
    r = old;
    for (int b = 0; b < 32; b++) if (wbe[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // -------------------------------------------------------------------------
  // Directed vector table
  // -------------------------------------------------------------------------
  typedef struct {
    logic [2:0]   op;
    logic [31:5]  addr;
    logic [255:0] wdata;
    logic [31:0]  wbe;
    bit           is_rd;
    logic [255:0] exp;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic [2:0] op, input logic [31:5] addr,
                              input logic [255:0] wd, input logic [31:0] wbe,
                              input bit is_rd, input logic [255:0] exp);
    vec_t v;
    v.op = op; v.addr = addr; v.wdata = wd; v.wbe = wbe; v.is_rd = is_rd; v.exp = exp;
    return v;
  endfunction

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [255:0] a5, ff4, p1, p2, p3, p4, p5, wd;
    logic [255:0] model1 [16];
    logic [9:0]   idx;
    logic [31:0]  wbe;
    logic [2:0]   op;
    int           nrd, rv_before, rd_issued, sel_op;
    bit           ok;

    a5  = {32{8'hA5}};
    ff4 = {{28{8'h00}}, {4{8'hFF}}};
    p1  = {32{8'h11}}; p2 = {32{8'h22}}; p3 = {32{8'h33}}; p4 = {32{8'h44}};
    p5  = {32{8'h5A}};

    vecs[0]  = mk(OP_WRITE,        27'h010, a5,            32'hFFFF_FFFF, 0, '0);
    vecs[1]  = mk(OP_READ,         27'h010, '0,            32'h0,         1, a5);
    vecs[2]  = mk(OP_WRITE,        27'h020, '0,            32'hFFFF_FFFF, 0, '0);
    vecs[3]  = mk(OP_WRITE,        27'h020, {32{8'hFF}},   32'h0000_000F, 0, '0);
    vecs[4]  = mk(OP_READ,         27'h020, '0,            32'h0,         1, ff4);
    vecs[5]  = mk(OP_WRITE,        27'h001, p1,            32'hFFFF_FFFF, 0, '0);
    vecs[6]  = mk(OP_WRITETHROUGH, 27'h002, p2,            32'hFFFF_FFFF, 0, '0);
    vecs[7]  = mk(OP_WRITE,        27'h003, p3,            32'hFFFF_FFFF, 0, '0);
    vecs[8]  = mk(OP_WRITETHROUGH, 27'h004, p4,            32'hFFFF_FFFF, 0, '0);
    vecs[9]  = mk(OP_READTHROUGH,  27'h004, '0,            32'h0,         1, p4);
    vecs[10] = mk(OP_READ,         27'h003, '0,            32'h0,         1, p3);
    vecs[11] = mk(OP_READTHROUGH,  27'h002, '0,            32'h0,         1, p2);
    vecs[12] = mk(OP_READ,         27'h001, '0,            32'h0,         1, p1);
    vecs[13] = mk(OP_WRITE,        27'h401, p5,            32'hFFFF_FFFF, 0, '0);
    vecs[14] = mk(OP_READ,         27'h001, '0,            32'h0,         1, p5);
    vecs[15] = mk(OP_OTHER4,       27'h001, '0,            32'hFFFF_FFFF, 0, '0);
    vecs[16] = mk(OP_OTHER7,       27'h001, '0,            32'hFFFF_FFFF, 0, '0);
    vecs[17] = mk(OP_READ,         27'h001, '0,            32'h0,         1, p5);
    vecs[18] = mk(OP_WRITE,        27'h020, {32{8'h77}},   32'h0,         0, '0);
    vecs[19] = mk(OP_READ,         27'h020, '0,            32'h0,         1, ff4);

    // ---------------- reset values ----------------
    repeat (3) @(negedge clk);
    check("reset_rvalid0", 256'(if0.arb2ltc_rvalid), 256'd0);
    check("reset_rdata0",  if0.arb2ltc_rdata,        256'd0);
    check("reset_stall0",  256'(if0.arb2ltc_stall),  256'd0);
    check("reset_stall1",  256'(if1.arb2ltc_stall),  256'd0);
    check("reset_stall2",  256'(if2.arb2ltc_stall),  256'd0);
    rst = 1'b0;
    @(negedge clk);
    check("thresh16_first_cycle", 256'(if2.arb2ltc_stall), 256'd1);

    // ---------------- directed table on dut0 ----------------
    sel = 0;
    nrd = 0;
    for (int i = 0; i < NV; i++) begin
      issue(vecs[i].op, vecs[i].addr, vecs[i].wdata, vecs[i].wbe, 1'b1, vecs[i].exp, ok);
      if (vecs[i].is_rd) nrd++;
    end
    idle(LAT + 3);
    check("drain_dut0",  256'(sbq.size()),  256'd0);
    check("reads_dut0",  256'(rd_pops[0]),  256'(nrd));

    // ---------------- reset with a read in flight ----------------
    rv_before = rv_seen[0];
    issue(OP_READ, 27'h010, '0, '0, 1'b0, '0, ok);
    @(negedge clk);
    req_valid = 1'b0;
    rst       = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_rvalid", 256'(if0.arb2ltc_rvalid), 256'd0);
    check("midrst_rdata",  if0.arb2ltc_rdata,        256'd0);
    repeat (6) @(negedge clk);
    check("midrst_dropped", 256'(rv_seen[0]), 256'(rv_before));
    issue(OP_READ, 27'h010, '0, '0, 1'b1, a5,  ok);
    issue(OP_READ, 27'h020, '0, '0, 1'b1, ff4, ok);
    idle(LAT + 3);
    check("midrst_drain", 256'(sbq.size()),  256'd0);
    check("midrst_reads", 256'(rv_seen[0]), 256'(rv_before + 2));

    // ---------------- random traffic under stall on dut1 ----------------
    sel        = 1;
    rand_phase = 1'b1;
    rd_issued  = 0;
    for (int i = 0; i < 16; i++) begin
      wd = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      issue(OP_WRITE, {17'd0, 10'(i)}, wd, 32'hFFFF_FFFF, 1'b1, '0, ok);
      if (ok) model1[i] = wd;
    end
    for (int i = 0; i < 1000; i++) begin
      idx    = 10'($urandom_range(0, 15));
      wd     = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      wbe    = $urandom;
      sel_op = $urandom_range(0, 5);
      case (sel_op)
        0:       op = OP_READ;
        1:       op = OP_READTHROUGH;
        2:       op = OP_WRITE;
        3:       op = OP_WRITETHROUGH;
        4:       op = 3'b101;
        default: op = 3'b110;
      endcase
      issue(op, {17'($urandom_range(0, 131071)), idx}, wd, wbe, 1'b1, model1[idx[3:0]], ok);
      if (ok && (op == OP_READ || op == OP_READTHROUGH)) rd_issued++;
      if (ok && (op == OP_WRITE || op == OP_WRITETHROUGH))
        model1[idx[3:0]] = merge(model1[idx[3:0]], wd, wbe);
    end
    idle(LAT + 3);
    rand_phase = 1'b0;
    check("drain_dut1", 256'(sbq.size()),  256'd0);
    check("reads_dut1", 256'(rd_pops[1]),  256'(rd_issued));
    check("stall_ratio_dut1",
          256'((st_hi * 100 >= st_tot * 35) && (st_hi * 100 <= st_tot * 65)), 256'd1);
    check("stall_seq_dut1", 256'(stall_mis1), 256'd0);

    // ---------------- STALL_THRESH=16: nothing ever accepted ----------------
    sel = 2;
    @(negedge clk);
    req_valid = 1'b1; req_op = OP_READ; req_addr = 27'h001;
    repeat (20) @(negedge clk);
    req_valid = 1'b0;
    repeat (LAT + 2) @(negedge clk);
    check("thresh16_no_rvalid", 256'(rv_seen[2]), 256'd0);
    check("stall_seq_dut2",     256'(stall_mis2), 256'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mcpu_mem_ltc_sram.md
# mcpu_mem_ltc_sram

Behavioural SRAM-backed responder for the LTC-side request interface driven by the memory arbiter. It stands in for the last-level cache in SoC bring-up and arbiter verification. It accepts one 256-bit line request per cycle, applies byte-enabled writes, and returns read data in order after a fixed pipelined latency. Optional pseudo-random stall injection stresses the initiator's hold and flow-control logic.

## Interface
Parameters:
- ADDR_BITS, 10, number of line-index bits; the array holds 2^ADDR_BITS lines of 256 bits.
- RD_LATENCY, 2, cycles from read acceptance to rvalid; legal range 1..8.
- STALL_EN, 0, when 1, enables LFSR-driven stall injection.
- STALL_THRESH, 4, stall asserted when lfsr[3:0] < STALL_THRESH (0 = never, 16 = always).

Ports:
- clkrst_mem_clk  in  1  clock; all logic on the rising edge.
- clkrst_mem_rst  in  1  reset, synchronous, active-high.
- arb2ltc_valid  in  1  request valid.
- arb2ltc_opcode  in  3  LTC opcode, encoded per the shared LTC opcode header.
- arb2ltc_addr  in  [31:5]  line address.
- arb2ltc_wdata  in  256  write data.
- arb2ltc_wbe  in  32  byte enables; bit i covers wdata[8i+7:8i].
- arb2ltc_stall  out  1  request not accepted this cycle; the initiator must hold its request.
- arb2ltc_rdata  out  256  read data.
- arb2ltc_rvalid  out  1  one-cycle pulse per completed read.

## Operation
- Acceptance: a request is accepted on a rising edge where arb2ltc_valid=1 and arb2ltc_stall=0. At most one request is accepted per cycle.
- Index: index = arb2ltc_addr[5+ADDR_BITS-1:5]. Higher address bits are ignored, so addresses alias modulo 2^ADDR_BITS lines.
- Opcode classes:
  - READ and READTHROUGH are reads.
  - WRITE and WRITETHROUGH are writes.
  - Every other opcode is accepted and produces no array update and no rvalid.
- Write: at the accept edge, each byte i with wbe[i]=1 is written from wdata; bytes with wbe[i]=0 are untouched. wbe=0 is a legal no-op write.
- Read: the array is sampled at the accept edge, and the sample is carried through a RD_LATENCY-deep pipe of {valid, data} registers. A read accepted on the cycle after a write to the same index returns the new data. The write completes first because a write and a read cannot be accepted in the same cycle.
- Ordering: read responses are strictly in acceptance order. There is no backpressure on rvalid, and outstanding reads are bounded only by RD_LATENCY.
- Stall injection, STALL_EN=1:
  - 16-bit Fibonacci LFSR, taps 16,14,13,11, reset value 16'hACE1, advances every cycle.
  - arb2ltc_stall is registered and equals (lfsr[3:0] < STALL_THRESH) from the previous cycle's LFSR state.
  - The stall is independent of arb2ltc_valid.
- STALL_EN=0: arb2ltc_stall is constant 0.
- Array contents are not reset and are undefined until written. Reads of unwritten lines return the array's current value.

## Timing
- Reset values: arb2ltc_stall=0, arb2ltc_rvalid=0, arb2ltc_rdata=0, read pipe valid bits=0, lfsr=16'hACE1.
- Reset mid-operation: all in-flight reads are dropped with no rvalid, and array contents are retained. The first rvalid after reset release comes only from a read accepted after release.
- Read latency: accept at edge T gives rvalid=1 with rdata valid during the cycle after edge T+RD_LATENCY-1, i.e. RD_LATENCY cycles after acceptance. rvalid=0 otherwise, and rdata holds its last value when rvalid=0.
- Throughput: back-to-back reads on N consecutive cycles produce N consecutive rvalid pulses.
- Write visibility: the write takes effect at its accept edge, and any read accepted at a later edge observes it.
- Stalled cycles: nothing is accepted, the array is not written, and the read pipe continues to advance (in-flight responses are never delayed by stall).

## Test plan
- Write then read: write addr 0x10 with wdata=all 0xA5 and wbe=0xFFFFFFFF; read 0x10 on the next cycle -> with RD_LATENCY=2, rvalid pulses exactly 2 cycles after the read is accepted, rdata=all 0xA5.
- Partial write: line holds all 0x00; write wdata=all 0xFF with wbe=0x0000000F -> a read returns bytes 0-3 = 0xFF and bytes 4-31 = 0x00.
- Pipelining and order: write indices 1-4 with distinct patterns; issue 4 consecutive reads 4,3,2,1 -> 4 consecutive rvalid cycles returning patterns 4,3,2,1.
- Aliasing and other opcodes: with ADDR_BITS=10, write addr 0x401 and read addr 0x001 -> same data. A non-read/non-write opcode -> no rvalid and no array change.
- Stall injection: STALL_EN=1, STALL_THRESH=8, with a checker-driven initiator holding requests under stall. Run 1000 random reads/writes against a reference model -> zero data mismatches, every request accepted exactly once, and stall asserted in roughly half of cycles. STALL_THRESH=16 -> stall always 1 after the first cycle and nothing accepted.
- Reset mid-flight: accept a read, assert clkrst_mem_rst one cycle later for 1 cycle -> no rvalid ever emitted for that read; array data written before reset is still readable afterwards.
